des_round_ctrl: RTL

DES_ROUND_CTRL -- requirements
Module: des_round_ctrl

---
 rtl/des_round_ctrl.sv | 69 ++++++
 1 files changed

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequences load, 16 Feistel rounds and final permutation for a DES datapath,
// with a per-round key-schedule rotate amount and a valid/ready handshake on both sides.
module des_round_ctrl #(
  parameter int ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       decrypt,
  output logic       load,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       final_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, OUT} state_t;
  state_t     state;
  logic [3:0] sub;
  logic [3:0] idx;
  logic       mode;
  logic       last_sub;
  assign last_sub = sub == 4'(ROUND_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sub   <= '0;
      idx   <= '0;
      mode  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= LOAD;
          mode  <= decrypt;
        end
        LOAD: begin
          state <= ROUND;
          sub   <= '0;
          idx   <= '0;
        end
        ROUND: if (last_sub) begin
          sub <= '0;
          idx <= idx + 4'd1;
          if (idx == 4'd15) state <= FINAL;
        end else sub <= sub + 4'd1;
        FINAL: state <= OUT;
        OUT: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign load      = state == LOAD;
  assign round_en  = state == ROUND && last_sub;
  assign final_en  = state == FINAL;
  assign out_valid = state == OUT;
  assign round_idx = idx;
  assign key_dir   = mode;
  // Decrypt skips the first rotate; otherwise rounds 0,1,8,15 rotate by one and the rest by two.
  always_comb
    key_shift = !round_en ? 2'd0 :
                (idx == 4'd0) ? (mode ? 2'd0 : 2'd1) :
                (idx == 4'd1 || idx == 4'd8 || idx == 4'd15) ? 2'd1 : 2'd2;
endmodule
